// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution unit.
// Opcodes, func3 encodings, FSM states.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } f3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic f3_illegal(
    input logic [2:0] f
  );
    return (f == 3'b010) || (f == 3'b011);
  endfunction

  function automatic logic f3_signed(
    input f3_t f
  );
    return (f == F3_BLT) || (f == F3_BGE);
  endfunction

  function automatic logic br_taken(
    input f3_t  f,
    input logic eq,
    input logic lt
  );
    logic r;
    r = 1'b0;
    unique case (f)
      F3_BEQ:          r = eq;
      F3_BNE:          r = !eq;
      F3_BLT, F3_BLTU: r = lt;
      F3_BGE, F3_BGEU: r = !lt;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cmp_chunk.sv
// One slice of the serial operand compare.
// Optional MSB flip turns a signed top slice into an unsigned compare.
module branch_cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sflip,
  output logic             eq,
  output logic             lt
);

  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);

  logic [CHUNK-1:0] af;
  logic [CHUNK-1:0] bf;

  // flip sign bits, then plain unsigned compare
  always_comb begin
    af = a ^ (sflip ? MSB : '0);
    bf = b ^ (sflip ? MSB : '0);
    eq = (af == bf);
    lt = (af < bf);
  end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution: serial MSB-first compare with early exit.
// Results held in DONE until the consumer takes them.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1v,
  input  logic [XLEN-1:0] rs2v,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misaligned,
  output logic            illegal
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] CTOP = CW'(NCHUNK - 1);

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  f3_t           f3_q;

  logic [NCHUNK-1:0][CHUNK-1:0] a_v;
  logic [NCHUNK-1:0][CHUNK-1:0] b_v;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic             sflip;
  logic             c_eq;
  logic             c_lt;
  logic             cmp_end;
  logic             cmp_tk;

  logic            accept;
  logic            is_br;
  logic            is_jal;
  logic            is_jalr;
  logic            bad_f3;
  logic [XLEN-1:0] sum_pc;
  logic [XLEN-1:0] sum_rs;
  logic            acc_tk;
  logic [XLEN-1:0] acc_tg;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_br    = (opcode == OP_BRANCH);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign bad_f3   = is_br && f3_illegal(func3);
  assign sum_pc   = pc + imm;
  assign sum_rs   = rs1v + imm;

  // pick the slice under the counter
  always_comb begin
    a_ch    = a_v[cnt];
    b_ch    = b_v[cnt];
    sflip   = f3_signed(f3_q) && (cnt == CTOP);
    cmp_end = (state == S_CMP) && (!c_eq || (cnt == '0));
    cmp_tk  = br_taken(f3_q, c_eq, c_lt);
  end

  branch_cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_cmp (
    .a     (a_ch),
    .b     (b_ch),
    .sflip (sflip),
    .eq    (c_eq),
    .lt    (c_lt)
  );

  // jump outcome known at accept time
  always_comb begin
    acc_tk = 1'b0;
    acc_tg = '0;
    unique case (1'b1)
      is_br: begin
        acc_tg = sum_pc;
      end
      is_jal: begin
        acc_tk = 1'b1;
        acc_tg = sum_pc;
      end
      is_jalr: begin
        acc_tk = 1'b1;
        acc_tg = {sum_rs[XLEN-1:1], 1'b0};
      end
      default: begin
        acc_tk = 1'b0;
        acc_tg = '0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_n = (is_br && !bad_f3) ? S_CMP : S_DONE;
      end
      S_CMP: begin
        if (cmp_end) state_n = S_DONE;
      end
      S_DONE: begin
        if (out_valid && out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // operand latch, chunk counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v        <= '0;
      b_v        <= '0;
      f3_q       <= F3_BEQ;
      cnt        <= '0;
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      target     <= '0;
      link       <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept) begin
      a_v        <= rs1v;
      b_v        <= rs2v;
      f3_q       <= f3_t'(func3);
      cnt        <= CTOP;
      taken      <= acc_tk;
      target     <= acc_tg;
      link       <= pc + XLEN'(4);
      misaligned <= acc_tk && (acc_tg[1:0] != 2'b00);
      illegal    <= bad_f3;
    end else if (state == S_CMP) begin
      if (cmp_end) begin
        taken      <= cmp_tk;
        misaligned <= cmp_tk && (target[1:0] != 2'b00);
        out_valid  <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (state == S_DONE) begin
      if (!out_valid)     out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Randomised bench for branch_unit with a behavioural model.
// Directed cases pin the model to hand-computed values.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1v = '0;
  logic [31:0] rs2v = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        taken;
  logic [31:0] target;
  logic [31:0] link;
  logic        misaligned;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic        e_tk;
  logic [31:0] e_tg;
  logic [31:0] e_ln;
  logic        e_mis;
  logic        e_ill;

  branch_unit #(
    .XLEN  (32),
    .CHUNK (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .func3      (func3),
    .pc         (pc),
    .imm        (imm),
    .rs1v       (rs1v),
    .rs2v       (rs2v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .target     (target),
    .link       (link),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // RV32I rules: full-width compares, latency from first differing byte
  function automatic void model(
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [31:0] p,
    input  logic [31:0] im,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        tk,
    output logic [31:0] tg,
    output logic [31:0] ln,
    output logic        mis,
    output logic        ill,
    output int          lat
  );
    tk = 1'b0;
    tg = '0;
    ln = p + 32'd4;
    ill = 1'b0;
    lat = 1;
    if (op == 7'b1100011) begin
      tg = p + im;
      if (f3 == 3'd2 || f3 == 3'd3) begin
        ill = 1'b1;
      end else begin
        lat = 4;
        for (int c = 3; c >= 0; c--) begin
          if (a[c*8 +: 8] != b[c*8 +: 8]) begin
            lat = 4 - c;
            break;
          end
        end
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          default: tk = (a >= b);
        endcase
      end
    end else if (op == 7'b1101111) begin
      tk = 1'b1;
      tg = p + im;
    end else if (op == 7'b1100111) begin
      tk = 1'b1;
      tg = (a + im) & 32'hFFFF_FFFE;
    end
    mis = tk && (tg[1:0] != 2'b00);
  endfunction

  // compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      check("taken", 32'(taken), 32'(e_tk));
      check("target", target, e_tg);
      check("link", link, e_ln);
      check("misaligned", 32'(misaligned), 32'(e_mis));
      check("illegal", 32'(illegal), 32'(e_ill));
    end
  end

  task automatic run_op(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [31:0] p,
    input logic [31:0] im,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          hold,
    input bit          pulse,
    output int         lat_o
  );
    int n;
    int lat;
    mon_en = 1'b0;
    model(op, f3, p, im, a, b, e_tk, e_tg, e_ln, e_mis, e_ill, lat);
    lat_o = lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    opcode = op;
    func3 = f3;
    pc = p;
    imm = im;
    rs1v = a;
    rs2v = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rs1v = $urandom;
    rs2v = $urandom;
    pc = $urandom;
    imm = $urandom;
    mon_en = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      check("in_ready_busy", 32'(in_ready), 32'd0);
      in_valid = pulse && (i == 1);
      opcode = 7'b1101111;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("held_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    mon_en = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("back_idle", 32'(in_ready), 32'd1);
    if (pulse) begin
      repeat (2) @(negedge clk);
      check("pulse_dropped", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic directed(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [31:0] p,
    input logic [31:0] im,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        l_tk,
    input logic [31:0] l_tg,
    input logic        l_mis,
    input logic        l_ill,
    input int          l_lat,
    input int          hold,
    input bit          pulse
  );
    logic        tk;
    logic [31:0] tg;
    logic [31:0] ln;
    logic        mis;
    logic        ill;
    int          lat;
    model(op, f3, p, im, a, b, tk, tg, ln, mis, ill, lat);
    check("pin_taken", 32'(tk), 32'(l_tk));
    check("pin_target", tg, l_tg);
    check("pin_link", ln, p + 32'd4);
    check("pin_mis", 32'(mis), 32'(l_mis));
    check("pin_ill", 32'(ill), 32'(l_ill));
    check("pin_lat", 32'(lat), 32'(l_lat));
    run_op(op, f3, p, im, a, b, hold, pulse, lat);
  endtask

  initial begin
    int          lat;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_link", link, 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    directed(7'h63, 3'd0, 32'h100, 32'h20, 32'h12345678, 32'h12345678,
             1'b1, 32'h120, 1'b0, 1'b0, 4, 0, 1'b0);
    directed(7'h63, 3'd4, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1,
             1'b1, 32'h120, 1'b0, 1'b0, 1, 0, 1'b0);
    directed(7'h63, 3'd6, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1,
             1'b0, 32'h120, 1'b0, 1'b0, 1, 0, 1'b0);
    directed(7'h63, 3'd1, 32'h100, 32'h20, 32'h1, 32'h0,
             1'b1, 32'h120, 1'b0, 1'b0, 4, 3, 1'b1);
    directed(7'h63, 3'd7, 32'h100, 32'h20, 32'h1, 32'h0,
             1'b1, 32'h120, 1'b0, 1'b0, 4, 0, 1'b0);
    directed(7'h67, 3'd0, 32'h100, 32'h4, 32'h1003, 32'h0,
             1'b1, 32'h1006, 1'b1, 1'b0, 1, 0, 1'b0);
    directed(7'h63, 3'd2, 32'h100, 32'h20, 32'h5, 32'h5,
             1'b0, 32'h120, 1'b0, 1'b1, 1, 0, 1'b0);
    directed(7'h6F, 3'd0, 32'h100, 32'h20, 32'h0, 32'h0,
             1'b1, 32'h120, 1'b0, 1'b0, 1, 1, 1'b0);
    directed(7'h33, 3'd0, 32'h100, 32'h20, 32'h7, 32'h7,
             1'b0, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0);
    directed(7'h63, 3'd5, 32'h100, 32'h20, 32'h80000000, 32'h7FFFFFFF,
             1'b0, 32'h120, 1'b0, 1'b0, 1, 0, 1'b0);
    directed(7'h63, 3'd0, 32'h100, 32'h22, 32'hA5, 32'hA5,
             1'b1, 32'h122, 1'b1, 1'b0, 4, 0, 1'b0);
    directed(7'h63, 3'd6, 32'h100, 32'h20, 32'h11223344, 32'h11223345,
             1'b1, 32'h120, 1'b0, 1'b0, 4, 0, 1'b0);

    // reset in the middle of a compare
    @(negedge clk);
    opcode = 7'h63;
    func3 = 3'd0;
    pc = 32'h100;
    imm = 32'h20;
    rs1v = 32'hCAFEF00D;
    rs2v = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_target", target, 32'd0);
    check("mid_rst_link", link, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    directed(7'h63, 3'd0, 32'h100, 32'h20, 32'h12345678, 32'h12345678,
             1'b1, 32'h120, 1'b0, 1'b0, 4, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) op = 7'h63;
      else if (sel == 7) op = 7'h6F;
      else if (sel == 8) op = 7'h67;
      else begin
        op = 7'($urandom);
        if (op == 7'h63 || op == 7'h6F || op == 7'h67) op = 7'h33;
      end
      f3 = 3'($urandom);
      a = $urandom;
      b = $urandom;
      for (int c = 3; c >= 0; c--)
        if ($urandom_range(0, 1) == 1) b[c*8 +: 8] = a[c*8 +: 8];
      if ($urandom_range(0, 7) == 0) b = a;
      run_op(op, f3, $urandom, $urandom, a, b,
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
